// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions and the
// controller/datapath mux codes that select EPC and CP0 read data.
package cp0_pkg;

   localparam logic [4:0] SEL_SR    = 5'd12;
   localparam logic [4:0] SEL_CAUSE = 5'd13;
   localparam logic [4:0] SEL_EPC   = 5'd14;
   localparam logic [4:0] SEL_PRID  = 5'd15;

   localparam int IM_HI   = 15;
   localparam int IM_LO   = 10;
   localparam int EXL_BIT = 1;
   localparam int IE_BIT  = 0;
   localparam int IM_W    = IM_HI - IM_LO + 1;

   localparam logic [2:0] NPC_ERET = 3'b100;
   localparam logic [1:0] WD_CP0   = 2'b11;

endpackage

// File: rtl/cp0_if.sv
// Bus between the FSM controller/datapath and CP0; the controller side is
// the master, CP0 itself is the slave.
interface cp0_if;

   logic [5:0]  HWInt;
   logic [4:0]  sel;
   logic [31:0] Din;
   logic [31:0] PC;
   logic        CP0_Wr;
   logic        EXL_set;
   logic        EXL_clr;
   logic [31:0] Dout;
   logic [31:0] EPC_out;
   logic        IntReq;

   modport master (
      output HWInt, sel, Din, PC, CP0_Wr, EXL_set, EXL_clr,
      input  Dout, EPC_out, IntReq
   );

   modport slave (
      input  HWInt, sel, Din, PC, CP0_Wr, EXL_set, EXL_clr,
      output Dout, EPC_out, IntReq
   );

endinterface

// File: rtl/cp0_int_logic.sv
// Cause.IP sampling register and the interrupt request equation; IntReq is
// derived from registered state only, so HWInt reaches it one cycle later.
module cp0_int_logic
   import cp0_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [IM_W-1:0] hw_int,
   input  logic [IM_W-1:0] im,
   input  logic            ie,
   input  logic            exl,
   output logic [IM_W-1:0] ip,
   output logic            int_req
);

   always_ff @(posedge clk) begin
      if (reset) begin
         ip <= '0;
      end else begin
         ip <= hw_int;
      end
   end

   assign int_req = (|(ip & im)) & ie & ~exl;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the multicycle MIPS32 core: SR, Cause, EPC and PrID,
// mtc0/mfc0 access, interrupt entry and eret handling.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VAL      = 32'h0000_1827,
   parameter int          HANDLER_ALIGN = 2
)
(
   input  logic    clk,
   input  logic    reset,
   cp0_if.slave    bus
);

   localparam logic [31:0] ALIGN_MASK = ~((32'd1 << HANDLER_ALIGN) - 32'd1);

   logic [IM_W-1:0] im;
   logic [IM_W-1:0] ip;
   logic            exl;
   logic            ie;
   logic [31:0]     epc;
   logic            int_req;
   logic            sr_wr;
   logic            epc_wr;
   logic [31:0]     sr_word;
   logic [31:0]     cause_word;

   // Interrupt entry shares the cycle with CP0_Wr and must shadow it.
   assign sr_wr  = bus.CP0_Wr && !bus.EXL_set && (bus.sel == SEL_SR);
   assign epc_wr = bus.CP0_Wr && !bus.EXL_set && (bus.sel == SEL_EPC);

   always_ff @(posedge clk) begin
      if (reset) begin
         im  <= '0;
         exl <= 1'b0;
         ie  <= 1'b0;
         epc <= '0;
      end else begin
         if (sr_wr) begin
            im <= bus.Din[IM_HI:IM_LO];
            ie <= bus.Din[IE_BIT];
         end
         if (bus.EXL_set) begin
            exl <= 1'b1;
         end else if (bus.EXL_clr) begin
            exl <= 1'b0;
         end else if (sr_wr) begin
            exl <= bus.Din[EXL_BIT];
         end
         if (bus.EXL_set) begin
            epc <= bus.PC;
         end else if (epc_wr) begin
            epc <= bus.Din & ALIGN_MASK;
         end
      end
   end

   cp0_int_logic u_int_logic (
      .clk     (clk),
      .reset   (reset),
      .hw_int  (bus.HWInt),
      .im      (im),
      .ie      (ie),
      .exl     (exl),
      .ip      (ip),
      .int_req (int_req)
   );

   always_comb begin
      sr_word                = '0;
      sr_word[IM_HI:IM_LO]   = im;
      sr_word[EXL_BIT]       = exl;
      sr_word[IE_BIT]        = ie;
      cause_word             = '0;
      cause_word[IM_HI:IM_LO] = ip;
   end

   always_comb begin
      case (bus.sel)
         SEL_SR:    bus.Dout = sr_word;
         SEL_CAUSE: bus.Dout = cause_word;
         SEL_EPC:   bus.Dout = epc;
         SEL_PRID:  bus.Dout = PRID_VAL;
         default:   bus.Dout = 32'h0;
      endcase
   end

   assign bus.EPC_out = epc;
   assign bus.IntReq  = int_req;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed vector table, hand sequences for
// read-during-write and simultaneous strobes, then random traffic vs a model.
module tb_cp0_unit;

   localparam logic [31:0] PRID = 32'h0000_1827;

   typedef struct {
      logic        rst;
      logic [5:0]  hw;
      logic [4:0]  sel;
      logic [31:0] din;
      logic [31:0] pc;
      logic        wr;
      logic        set;
      logic        clr;
      logic [31:0] exp_dout;
      logic [31:0] exp_epc;
      logic        exp_irq;
   } vec_t;

   logic clk;
   logic reset;
   cp0_if bus ();

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl_sr    = '0;
   logic [31:0] mdl_cause = '0;
   logic [31:0] mdl_epc   = '0;

   vec_t vecs[$];

   cp0_unit #(.PRID_VAL(PRID), .HANDLER_ALIGN(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input logic [4:0] s);
      case (s)
         5'd12:   return mdl_sr;
         5'd13:   return mdl_cause;
         5'd14:   return mdl_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_irq();
      logic [5:0] pend;
      pend = mdl_cause[15:10] & mdl_sr[15:10];
      return (pend != 6'd0) && mdl_sr[0] && !mdl_sr[1];
   endfunction

   // Architectural rules applied to the whole-register view at each edge.
   task automatic model_update();
      if (reset) begin
         mdl_sr    = 32'h0;
         mdl_cause = 32'h0;
         mdl_epc   = 32'h0;
      end else begin
         mdl_cause = {16'h0, bus.HWInt, 10'h0};
         if (bus.EXL_set) begin
            mdl_epc = bus.PC;
            mdl_sr  = mdl_sr | 32'h2;
         end else begin
            if (bus.CP0_Wr && bus.sel == 5'd12) mdl_sr = bus.Din & 32'h0000_FC03;
            if (bus.EXL_clr) mdl_sr = mdl_sr & ~32'h2;
            if (bus.CP0_Wr && bus.sel == 5'd14) mdl_epc = bus.Din & ~32'h3;
         end
      end
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic [5:0] hw, input logic [4:0] s,
                                 input logic [31:0] din, input logic [31:0] pc,
                                 input logic wr, input logic set, input logic clr);
      @(negedge clk);
      reset       = r;
      bus.HWInt   = hw;
      bus.sel     = s;
      bus.Din     = din;
      bus.PC      = pc;
      bus.CP0_Wr  = wr;
      bus.EXL_set = set;
      bus.EXL_clr = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      reset = 1'b1;
      bus.HWInt = '0; bus.sel = '0; bus.Din = '0; bus.PC = '0;
      bus.CP0_Wr = 1'b0; bus.EXL_set = 1'b0; bus.EXL_clr = 1'b0;

      //                rst  hw     sel    din            pc            wr set clr  dout           epc            irq
      vecs.push_back(vec_t'{1, 6'h3F, 5'd12, 32'h0,         32'h0,        0, 0, 0, 32'h0,         32'h0,         0});
      vecs.push_back(vec_t'{1, 6'h3F, 5'd13, 32'h0,         32'h0,        0, 0, 0, 32'h0,         32'h0,         0});
      vecs.push_back(vec_t'{1, 6'h3F, 5'd14, 32'h0,         32'h0,        0, 0, 0, 32'h0,         32'h0,         0});
      vecs.push_back(vec_t'{0, 6'h3F, 5'd13, 32'h0,         32'h0,        0, 0, 0, 32'h0000_FC00, 32'h0,         0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd13, 32'h0,         32'h0,        0, 0, 0, 32'h0000_0400, 32'h0,         0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd12, 32'h0000_0401, 32'h0,        1, 0, 0, 32'h0000_0401, 32'h0,         1});
      vecs.push_back(vec_t'{0, 6'h01, 5'd12, 32'h0,         32'h0000_3010, 0, 1, 0, 32'h0000_0403, 32'h0000_3010, 0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd12, 32'h0,         32'h0,        0, 0, 1, 32'h0000_0401, 32'h0000_3010, 1});
      vecs.push_back(vec_t'{0, 6'h01, 5'd14, 32'h0000_5555, 32'h0000_3020, 1, 1, 0, 32'h0000_3020, 32'h0000_3020, 0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd14, 32'h0000_3007, 32'h0,        1, 0, 0, 32'h0000_3004, 32'h0000_3004, 0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd13, 32'hFFFF_FFFF, 32'h0,        1, 0, 0, 32'h0000_0400, 32'h0000_3004, 0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd15, 32'h0,         32'h0,        0, 0, 0, PRID,          32'h0000_3004, 0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd3,  32'h0,         32'h0,        0, 0, 0, 32'h0,         32'h0000_3004, 0});
      vecs.push_back(vec_t'{0, 6'h01, 5'd12, 32'h0000_0403, 32'h0,        1, 0, 1, 32'h0000_0401, 32'h0000_3004, 1});
      vecs.push_back(vec_t'{0, 6'h00, 5'd12, 32'h0,         32'h0,        0, 0, 0, 32'h0000_0401, 32'h0000_3004, 0});
      vecs.push_back(vec_t'{0, 6'h02, 5'd13, 32'h0,         32'h0,        0, 0, 0, 32'h0000_0800, 32'h0000_3004, 0});
      vecs.push_back(vec_t'{0, 6'h02, 5'd12, 32'hFFFF_0BFD, 32'h0,        1, 0, 0, 32'h0000_0801, 32'h0000_3004, 1});
      vecs.push_back(vec_t'{1, 6'h02, 5'd12, 32'h0,         32'h0,        0, 0, 0, 32'h0,         32'h0,         0});
      vecs.push_back(vec_t'{0, 6'h00, 5'd14, 32'h0,         32'h0,        0, 0, 0, 32'h0,         32'h0,         0});

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].rst, vecs[i].hw, vecs[i].sel, vecs[i].din, vecs[i].pc,
                        vecs[i].wr, vecs[i].set, vecs[i].clr);
         tick();
         check_output($sformatf("vec%0d_dout", i), bus.Dout, vecs[i].exp_dout);
         check_output($sformatf("vec%0d_epc", i), bus.EPC_out, vecs[i].exp_epc);
         check_output($sformatf("vec%0d_irq", i), {31'h0, bus.IntReq}, {31'h0, vecs[i].exp_irq});
      end

      // Read-during-write: old SR visible before the edge, new one after.
      apply_stimulus(0, 6'h00, 5'd12, 32'h0000_FC01, 32'h0, 1, 0, 0);
      #1;
      check_output("rdw_old_sr", bus.Dout, 32'h0);
      tick();
      check_output("rdw_new_sr", bus.Dout, 32'h0000_FC01);

      // Entry and eret together: entry wins and EPC is captured.
      apply_stimulus(0, 6'h3F, 5'd12, 32'h0, 32'h0000_4000, 0, 1, 1);
      tick();
      check_output("set_clr_sr", bus.Dout, 32'h0000_FC03);
      check_output("set_clr_epc", bus.EPC_out, 32'h0000_4000);
      check_output("set_clr_irq", {31'h0, bus.IntReq}, 32'h0);
      apply_stimulus(0, 6'h3F, 5'd12, 32'h0, 32'h0, 0, 0, 1);
      tick();
      check_output("eret_sr", bus.Dout, 32'h0000_FC01);
      check_output("eret_epc", bus.EPC_out, 32'h0000_4000);
      check_output("eret_irq", {31'h0, bus.IntReq}, 32'h1);

      begin
         logic [5:0] hw_cur;
         logic [4:0] s;
         hw_cur = 6'h00;
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) hw_cur = 6'($urandom);
            case ($urandom_range(0, 5))
               0: s = 5'd12;
               1: s = 5'd13;
               2: s = 5'd14;
               3: s = 5'd15;
               default: s = 5'($urandom);
            endcase
            apply_stimulus(($urandom_range(0, 49) == 0), hw_cur, s, $urandom, $urandom,
                           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 7) == 0));
            #1;
            check_output("rnd_pre_dout", bus.Dout, model_read(bus.sel));
            tick();
            check_output("rnd_dout", bus.Dout, model_read(bus.sel));
            check_output("rnd_epc", bus.EPC_out, mdl_epc);
            check_output("rnd_irq", {31'h0, bus.IntReq}, {31'h0, model_irq()});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
